// File: rtl/suma_uno_pkg.sv
// Shared widths and types for the suma_uno incrementer.
package suma_uno_pkg;

    localparam int unsigned SUMA_UNO_WIDTH = 16;
    localparam int unsigned NIBBLE         = 4;

    typedef logic [15:0] tupla_t;

    // Number of nibble slices needed for a given operand width.
    function automatic int unsigned nib_count(input int unsigned w);
        return w / NIBBLE;
    endfunction

endpackage

// File: rtl/suma_uno_nibble.sv
// Combinational 4-bit incrementer slice: sum = a + cin, with carry-out and all-ones propagate.
import suma_uno_pkg::*;

module suma_uno_nibble (
    input  logic [3:0] a,
    input  logic       cin,
    output logic [3:0] sum_c,
    output logic       cout_c,
    output logic       prop_c
);

    always_comb begin
        prop_c = &a;
        sum_c  = a + 4'(cin);
        cout_c = cin & prop_c;
    end

endmodule

// File: rtl/suma_uno.sv
// Registered increment-by-one with carry (wrap) and zero flags, one cycle of latency.
// Optional saturating mode: define SUMA_UNO_SAT_EN to clamp all-ones input at all-ones.
import suma_uno_pkg::*;

module suma_uno #(
    parameter int unsigned WIDTH = SUMA_UNO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] tupla,
    output logic             out_valid,
    output logic [WIDTH-1:0] respuesta,
    output logic             carry,
    output logic             zero
);

    localparam int unsigned NIB_CNT = nib_count(WIDTH);

    logic [NIB_CNT-1:0] prop_c;
    logic [NIB_CNT-1:0] cin_c;
    logic [NIB_CNT-1:0] cout_c;
    logic [WIDTH-1:0]   sum_c;
    logic [WIDTH-1:0]   res_c;
    logic               wrap_c;
    logic               zero_c;
    logic               unused_c;

    // Lookahead: nibble k sees a carry-in only if every lower nibble is all ones.
    always_comb begin
        logic all_p;
        cin_c = '0;
        for (int k = 0; k < int'(NIB_CNT); k++) begin
            all_p = 1'b1;
            for (int j = 0; j < k; j++) begin
                all_p = all_p & prop_c[j];
            end
            cin_c[k] = all_p;
        end
    end

    for (genvar k = 0; k < int'(NIB_CNT); k++) begin : g_nib
        suma_uno_nibble u_nib (
            .a      (tupla[k*NIBBLE +: NIBBLE]),
            .cin    (cin_c[k]),
            .sum_c  (sum_c[k*NIBBLE +: NIBBLE]),
            .cout_c (cout_c[k]),
            .prop_c (prop_c[k])
        );
    end

    // Lower carry-outs are implied by the lookahead terms; only the top one is the wrap.
    assign unused_c = ^{cout_c[NIB_CNT-2:0], prop_c[NIB_CNT-1]};

    always_comb begin
        wrap_c = cout_c[NIB_CNT-1];
`ifdef SUMA_UNO_SAT_EN
        res_c  = wrap_c ? '1 : sum_c;
`else
        res_c  = sum_c;
`endif
        zero_c = (res_c == '0);
    end

    // Result registers load only on a valid operand; out_valid tracks in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            respuesta <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                respuesta <= res_c;
                carry     <= wrap_c;
                zero      <= zero_c;
            end
        end
    end

endmodule

// File: tb/tb_suma_uno.sv
// Directed self-checking bench for suma_uno (wrapping or SUMA_UNO_SAT_EN build).
`timescale 1ns/1ps
import suma_uno_pkg::*;

module tb_suma_uno;

    logic   clk;
    logic   rst;
    logic   in_valid;
    tupla_t tupla;
    logic   out_valid;
    tupla_t respuesta;
    logic   carry;
    logic   zero;

    int n_cmp = 0;
    int n_bad = 0;

    suma_uno dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .tupla     (tupla),
        .out_valid (out_valid),
        .respuesta (respuesta),
        .carry     (carry),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, return just after the next rising edge.
    task automatic step(input logic v, input logic [15:0] t);
        @(negedge clk);
        in_valid = v;
        tupla    = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] chain_in  [4];
        logic [15:0] chain_exp [4];
        chain_in  = '{16'h000F, 16'h00FF, 16'h0FFF, 16'h7FFF};
        chain_exp = '{16'h0010, 16'h0100, 16'h1000, 16'h8000};

        rst      = 1'b1;
        in_valid = 1'b0;
        tupla    = 16'h0000;
        #3;
        chk("rst_valid", 16'(out_valid), 16'h0);
        chk("rst_resp",  respuesta,      16'h0000);
        chk("rst_carry", 16'(carry),     16'h0);
        chk("rst_zero",  16'(zero),      16'h0);
        @(negedge clk);
        rst = 1'b0;

        // First transaction
        step(1'b1, 16'h0000);
        chk("t1_valid", 16'(out_valid), 16'h1);
        chk("t1_resp",  respuesta,      16'h0001);
        chk("t1_carry", 16'(carry),     16'h0);
        chk("t1_zero",  16'(zero),      16'h0);

        // Back-to-back sweep
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 16'(i * 16));
            chk("sweep_resp",  respuesta,      16'(i * 16 + 1));
            chk("sweep_valid", 16'(out_valid), 16'h1);
        end

        // Nibble carry chain
        for (int i = 0; i < 4; i++) begin
            step(1'b1, chain_in[i]);
            chk("chain_resp",  respuesta,  chain_exp[i]);
            chk("chain_carry", 16'(carry), 16'h0);
            chk("chain_zero",  16'(zero),  16'h0);
        end

        // All-ones operand, then hold with X on tupla
        step(1'b1, 16'hFFFF);
`ifdef SUMA_UNO_SAT_EN
        chk("ffff_resp", respuesta,  16'hFFFF);
        chk("ffff_zero", 16'(zero),  16'h0);
`else
        chk("ffff_resp", respuesta,  16'h0000);
        chk("ffff_zero", 16'(zero),  16'h1);
`endif
        chk("ffff_carry", 16'(carry), 16'h1);
        step(1'b0, 16'hxxxx);
        chk("ffff_hold_valid", 16'(out_valid), 16'h0);
        chk("ffff_hold_carry", 16'(carry),     16'h1);
`ifdef SUMA_UNO_SAT_EN
        chk("ffff_hold_resp", respuesta, 16'hFFFF);
`else
        chk("ffff_hold_resp", respuesta, 16'h0000);
`endif

        // in_valid low holds the previous result
        step(1'b1, 16'h1233);
        chk("t5_resp",  respuesta,  16'h1234);
        chk("t5_carry", 16'(carry), 16'h0);
        step(1'b0, 16'hxxxx);
        chk("t5_valid",      16'(out_valid), 16'h0);
        chk("t5_hold_resp",  respuesta,      16'h1234);
        chk("t5_hold_carry", 16'(carry),     16'h0);
        chk("t5_hold_zero",  16'(zero),      16'h0);
        step(1'b0, 16'hxxxx);
        chk("t5_hold2_resp", respuesta, 16'h1234);

        // Asynchronous reset between edges while streaming
        step(1'b1, 16'h00A0);
        step(1'b1, 16'h00A1);
        chk("t6_pre_resp", respuesta, 16'h00A2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid", 16'(out_valid), 16'h0);
        chk("t6_resp",  respuesta,      16'h0000);
        chk("t6_carry", 16'(carry),     16'h0);
        chk("t6_zero",  16'(zero),      16'h0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        step(1'b0, 16'hxxxx);
        chk("t6_after_valid", 16'(out_valid), 16'h0);
        chk("t6_after_resp",  respuesta,      16'h0000);
        step(1'b1, 16'h4321);
        chk("t6_resume_resp",  respuesta,      16'h4322);
        chk("t6_resume_valid", 16'(out_valid), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
